// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin RAM arbiter: width helpers,
// a one-hot encoder and the rotating-priority find-first used by the scheduler.
package mem_arb_pkg;

    localparam int MAX_PORTS  = 8;
    localparam int PORT_IDX_W = 3;

    typedef logic [MAX_PORTS-1:0]  port_vec_t;
    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    typedef struct packed {
        logic      found;
        port_idx_t idx;
    } pick_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int burst_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    function automatic port_vec_t port_onehot(input port_idx_t idx);
        port_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First set bit of req, scanning start, start+1, ... modulo n (start <= n).
    function automatic pick_t rr_find_first(input port_vec_t req, input int start, input int n);
        pick_t pick;
        int    p;
        pick = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            p = start + i;
            if (p >= n) begin
                p = p - n;
            end
            if (!pick.found && (i < n) && req[p[PORT_IDX_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = p[PORT_IDX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_port_fifo.sv
// Per-port request FIFO with first-word fall-through read; push is accepted
// when full only if a pop happens on the same edge.
module mem_arb_port_fifo
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = 42,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Multi-port RAM arbiter: per-port FIFOs, burst-limited round-robin issue, one-hot read return.
// Optional MEM_ARB_PORT0_PRIORITY_EN: port 0 preempts rotation whenever its FIFO is non-empty.
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 25,
    parameter int DATA_WIDTH      = 16,
    parameter int PERIPHERALS     = 4,
    parameter int PORT_FIFO_DEPTH = 8,
    parameter int MAX_BURST       = 4,
    parameter int RAM_LATENCY     = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [ADDRESS_WIDTH*PERIPHERALS-1:0] req_addr,
    input  logic [PERIPHERALS-1:0]               req_wr,
    input  logic [DATA_WIDTH*PERIPHERALS-1:0]    req_wdata,
    input  logic [PERIPHERALS-1:0]               req_valid,
    output logic [PERIPHERALS-1:0]               req_ready,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic [PERIPHERALS-1:0]               rd_valid,
    output logic [ADDRESS_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    output logic                                 mem_wren,
    output logic                                 mem_en,
    input  logic [DATA_WIDTH-1:0]                mem_q
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int EW = AW + DW + 1;
    localparam int CW = count_width(PORT_FIFO_DEPTH);
    localparam int BW = burst_width(MAX_BURST);

    logic [EW-1:0]          fifo_wdata [PERIPHERALS];
    logic [EW-1:0]          fifo_rdata [PERIPHERALS];
    logic [CW-1:0]          fifo_count [PERIPHERALS];
    logic [PERIPHERALS-1:0] fifo_push;
    logic [PERIPHERALS-1:0] fifo_pop;
    logic [PERIPHERALS-1:0] fifo_full;
    logic [PERIPHERALS-1:0] fifo_empty;
    logic [PERIPHERALS-1:0] grant;
    port_vec_t              nonempty_vec;

    port_idx_t              cur;
    logic [BW-1:0]          burst_cnt;
    port_idx_t              issue_port;

    logic                   sel_valid;
    logic                   sel_cont;
    logic                   sel_prio;
    port_idx_t              sel_idx;
    pick_t                  rr_pick;
    logic [EW-1:0]          sel_entry;

    logic [PERIPHERALS-1:0] rd_pipe [RAM_LATENCY];

    // Entry layout: {wr, addr, wdata}
    for (genvar k = 0; k < PERIPHERALS; k++) begin : g_port
        assign fifo_wdata[k] = {req_wr[k], req_addr[k*AW +: AW], req_wdata[k*DW +: DW]};
        assign fifo_push[k]  = req_valid[k] && !fifo_full[k];
        assign fifo_pop[k]   = grant[k] && !fifo_empty[k];
        assign req_ready[k]  = !fifo_full[k];

        mem_arb_port_fifo #(
            .WIDTH (EW),
            .DEPTH (PORT_FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (fifo_push[k]),
            .wdata (fifo_wdata[k]),
            .pop   (fifo_pop[k]),
            .rdata (fifo_rdata[k]),
            .full  (fifo_full[k]),
            .empty (fifo_empty[k]),
            .count (fifo_count[k])
        );
    end

    always_comb begin
        nonempty_vec = '0;
        for (int k = 0; k < PERIPHERALS; k++) begin
            nonempty_vec[k] = (fifo_count[k] != '0);
        end
    end

    // The rotating scan starts after cur and visits cur last, so an exhausted
    // burst is handed off whenever anyone else is waiting.
    always_comb begin
        sel_valid = 1'b0;
        sel_cont  = 1'b0;
        sel_prio  = 1'b0;
        sel_idx   = cur;
        rr_pick   = rr_find_first(nonempty_vec, int'(cur) + 1, PERIPHERALS);
`ifdef MEM_ARB_PORT0_PRIORITY_EN
        if (nonempty_vec[0]) begin
            sel_valid = 1'b1;
            sel_prio  = 1'b1;
            sel_idx   = '0;
        end else
`endif
        if (nonempty_vec[cur] && (burst_cnt < BW'(MAX_BURST))) begin
            sel_valid = 1'b1;
            sel_cont  = 1'b1;
            sel_idx   = cur;
        end else if (rr_pick.found) begin
            sel_valid = 1'b1;
            sel_idx   = rr_pick.idx;
        end
    end

    assign grant = sel_valid ? PERIPHERALS'(port_onehot(sel_idx)) : '0;

    always_comb begin
        sel_entry = '0;
        for (int k = 0; k < PERIPHERALS; k++) begin
            if (sel_idx == PORT_IDX_W'(k)) begin
                sel_entry = fifo_rdata[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_wren   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            issue_port <= '0;
            cur        <= '0;
            burst_cnt  <= '0;
        end else if (sel_valid) begin
            mem_en     <= 1'b1;
            mem_wren   <= sel_entry[EW-1];
            mem_addr   <= sel_entry[EW-2 -: AW];
            mem_wdata  <= sel_entry[DW-1:0];
            issue_port <= sel_idx;
            // Priority grants leave the rotation state untouched.
            if (!sel_prio) begin
                if (sel_cont) begin
                    burst_cnt <= burst_cnt + BW'(1);
                end else begin
                    cur       <= sel_idx;
                    burst_cnt <= BW'(1);
                end
            end
        end else begin
            mem_en    <= 1'b0;
            mem_wren  <= 1'b0;
            burst_cnt <= '0;
        end
    end

    // Return pipe: one-hot owner of each issued read, RAM_LATENCY stages deep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_pipe[0] <= (mem_en && !mem_wren) ? PERIPHERALS'(port_onehot(issue_port)) : '0;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign rd_valid = rd_pipe[RAM_LATENCY-1];
    assign rd_data  = mem_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: directed scenarios plus random traffic against a
// queue-based reference model and a behavioural RAM.
module tb_mem_arbiter_rr;

    localparam int AW    = 25;
    localparam int DW    = 16;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int MB    = 4;
    localparam int RL    = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW*N-1:0]   req_addr;
    logic [N-1:0]      req_wr;
    logic [DW*N-1:0]   req_wdata;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     rd_data;
    logic [N-1:0]      rd_valid;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_wren;
    logic              mem_en;
    logic [DW-1:0]     mem_q;

    always #5 clk = ~clk;

    mem_arbiter_rr #(
        .ADDRESS_WIDTH   (AW),
        .DATA_WIDTH      (DW),
        .PERIPHERALS     (N),
        .PORT_FIFO_DEPTH (DEPTH),
        .MAX_BURST       (MB),
        .RAM_LATENCY     (RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_addr  (req_addr),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_en    (mem_en),
        .mem_q     (mem_q)
    );

    // External RAM: samples the op on the edge after mem_en, data appears RL-1 edges later
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] q_pipe [RL];

    always @(posedge clk) begin
        for (int i = RL - 1; i > 0; i--) q_pipe[i] = q_pipe[i-1];
        q_pipe[0] = '0;
        if (mem_en) begin
            if (mem_wren) ram[mem_addr[9:0]] = mem_wdata;
            else          q_pipe[0] = ram[mem_addr[9:0]];
        end
        mem_q = q_pipe[RL-1];
    end

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    req_t          mq [N][$];
    int            m_cur, m_burst, m_port;
    logic          m_en, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [N-1:0]  pv [RL];
    logic [DW-1:0] pd [RL];
    logic [DW-1:0] ref_mem [1024];
    logic [N-1:0]  pend_rise;
    logic [N-1:0]  saw_full;
    int            issue_log [$];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[k]          = v;
        req_wr[k]             = wr;
        req_addr[k*AW +: AW]  = a;
        req_wdata[k*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_wr    = '0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) mq[k].delete();
        m_cur = 0; m_burst = 0; m_port = 0;
        m_en = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
        for (int i = 0; i < RL; i++) begin
            pv[i] = '0;
            pd[i] = '0;
        end
        pend_rise = '0;
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic step();
        logic [N-1:0] exp_ready, acc, fp_mask;
        int   sel, p;
        bit   cont, prio;
        req_t e;
        @(negedge clk);
        for (int k = 0; k < N; k++) exp_ready[k] = (mq[k].size() < DEPTH);
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        for (int k = 0; k < N; k++) if (!req_ready[k]) saw_full[k] = 1'b1;
        acc  = req_valid & exp_ready;
        sel  = -1;
        cont = 0;
        prio = 0;
`ifdef MEM_ARB_PORT0_PRIORITY_EN
        if (mq[0].size() > 0) begin
            sel  = 0;
            prio = 1;
        end
`endif
        if (sel < 0) begin
            if (mq[m_cur].size() > 0 && m_burst < MB) begin
                sel  = m_cur;
                cont = 1;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    p = (m_cur + i) % N;
                    if (sel < 0 && mq[p].size() > 0) sel = p;
                end
            end
        end
        for (int k = 0; k < N; k++) fp_mask[k] = (sel == k) && (mq[k].size() == DEPTH);

        @(posedge clk);
        #1;
        for (int i = RL - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = (m_en && !m_wr) ? (N'(1) << m_port) : '0;
        pd[0] = (m_en && !m_wr) ? ref_mem[m_addr[9:0]] : '0;
        if (m_en && m_wr) ref_mem[m_addr[9:0]] = m_wdata;

        if (sel >= 0) begin
            e       = mq[sel].pop_front();
            m_en    = 1'b1;
            m_wr    = e.wr;
            m_addr  = e.addr;
            m_wdata = e.wdata;
            m_port  = sel;
            if (!prio) begin
                if (cont) m_burst++;
                else begin
                    m_cur   = sel;
                    m_burst = 1;
                end
            end
        end else begin
            m_en    = 1'b0;
            m_wr    = 1'b0;
            m_burst = 0;
        end
        issue_log.push_back(sel);

        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                e.wr    = req_wr[k];
                e.addr  = req_addr[k*AW +: AW];
                e.wdata = req_wdata[k*DW +: DW];
                mq[k].push_back(e);
            end
        end

        chk("mem_en", 64'(mem_en), 64'(m_en));
        chk("mem_wren", 64'(mem_wren), 64'(m_wr));
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        chk("rd_valid", 64'(rd_valid), 64'(pv[RL-1]));
        if (pv[RL-1] != '0) chk("rd_data", 64'(rd_data), 64'(pd[RL-1]));
        for (int k = 0; k < N; k++) if (pend_rise[k]) chk("ready_rise_after_full_pop", 64'(req_ready[k]), 64'd1);
        pend_rise = fp_mask;
    endtask

    task automatic do_reset();
        clear_reqs();
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        issue_log.delete();
    endtask

    task automatic random_traffic(input int steps);
        for (int s = 0; s < steps; s++) begin
            for (int k = 0; k < N; k++)
                set_req(k, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
                        AW'($urandom_range(0, 63)), DW'($urandom));
            step();
        end
    endtask

    int exp_order [12];

    initial begin
        reset     = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        clear_reqs();
        mem_q     = '0;
        saw_full  = '0;
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < RL; i++) q_pipe[i] = '0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'hF);
        chk("reset_rd_valid", 64'(rd_valid), 64'h0);
        chk("reset_mem_en", 64'(mem_en), 64'h0);
        chk("reset_mem_wren", 64'(mem_wren), 64'h0);
        chk("reset_mem_addr", 64'(mem_addr), 64'h0);
        chk("reset_mem_wdata", 64'(mem_wdata), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Write then read the same word from different ports
        set_req(2, 1'b1, 1'b1, AW'('h10), 16'hBEEF);
        step();
        set_req(2, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b1, 1'b0, AW'('h10), 16'h0);
        step();
        clear_reqs();
        step();
        chk("read_issue_en", 64'(mem_en), 64'd1);
        step();
        chk("rd_valid_early", 64'(rd_valid), 64'h0);
        step();
        chk("rd_valid_port1", 64'(rd_valid), 64'b0010);
        chk("rd_data_beef", 64'(rd_data), 64'hBEEF);
        repeat (3) step();

        // Two ports competing under the burst limit
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b1, 1'b0, AW'('h100 + i), DW'(i));
            set_req(3, 1'b1, 1'b0, AW'('h300 + i), DW'(i));
            step();
        end
        clear_reqs();
        repeat (10) step();
`ifdef MEM_ARB_PORT0_PRIORITY_EN
        exp_order = '{0, 0, 0, 0, 0, 0, 3, 3, 3, 3, 3, 3};
`else
        exp_order = '{0, 0, 0, 0, 3, 3, 3, 3, 0, 0, 3, 3};
`endif
        chk("min_latency_idle", 64'(issue_log[0]), 64'(-1));
        for (int i = 0; i < 12; i++) chk("rr_order", 64'(issue_log[1 + i]), 64'(exp_order[i]));
        chk("rr_after_last", 64'(issue_log[13]), 64'(-1));

`ifdef MEM_ARB_PORT0_PRIORITY_EN
        // Port 0 stream starves port 2 until it drains, then port 2 bursts
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_req(0, 1'b1, 1'b0, AW'('h40 + i), DW'(i));
            set_req(2, i < 4, 1'b0, AW'('h80 + i), DW'(i));
            step();
        end
        clear_reqs();
        repeat (8) step();
        for (int i = 1; i <= 10; i++) chk("prio_port0", 64'(issue_log[i]), 64'd0);
        for (int i = 11; i <= 14; i++) chk("prio_port2_burst", 64'(issue_log[i]), 64'd2);
`endif

        // All ports saturating: FIFOs fill, ready drops, order kept
        do_reset();
        saw_full = '0;
        for (int s = 0; s < 24; s++) begin
            for (int k = 0; k < N; k++)
                set_req(k, 1'b1, s[0], AW'(k * 64 + s), DW'($urandom));
            step();
        end
        clear_reqs();
        repeat (40) step();
        chk("port1_backpressure", 64'(saw_full[1]), 64'd1);

        // Random traffic, async reset between edges, more random traffic
        do_reset();
        random_traffic(200);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_mem_en", 64'(mem_en), 64'h0);
        chk("midreset_mem_wren", 64'(mem_wren), 64'h0);
        chk("midreset_rd_valid", 64'(rd_valid), 64'h0);
        chk("midreset_req_ready", 64'(req_ready), 64'hF);
        clear_reqs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (RL + 3) step();
        random_traffic(200);
        clear_reqs();
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
